spi_reg_bank: RTL and testbench

- Parametrised SPI slave register bank; successor to the single-register SPI write block.
- Holds N_REG registers of NBIT bits each, at consecutive 7-bit addresses starting at BASE_ADR.
- Each SPI transaction is an address/command byte followed by one or more data words; the block supports both write and read-back on miso.
- Sits between the board SPI master (MCU) and control registers in the fabric (attenuators, mode words, etc.). All SPI inputs are oversampled in the clk domain.

---
 rtl/spi_reg_bank.sv | 177 +++++++++++++++++
 tb/tb_spi_reg_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank: N_REG x NBIT registers at BASE_ADR, write and read-back on miso.
// Optional burst auto-increment across consecutive registers is enabled by SPI_REG_BANK_AUTOINC_EN.
module spi_reg_bank #(
  parameter int              NBIT     = 16,
  parameter int              N_REG    = 4,
  parameter int              BASE_ADR = 1,
  parameter logic [NBIT-1:0] RST_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic [N_REG*NBIT-1:0] out,
  output logic [N_REG-1:0]      wr_stb,
  output logic                  busy
);

  localparam int IW = (N_REG > 1) ? $clog2(N_REG) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WR_DATA, RD_DATA, SKIP} state_t;

  state_t          state;
  logic [4:0]      sclk_sr;
  logic [4:0]      cs_sr;
  logic [2:0]      mosi_sr;
  logic [5:0]      cnt;
  logic [NBIT-1:0] sh;
  logic [NBIT-1:0] rd_sr;
  logic [IW-1:0]   idx;
  logic            hold;
  logic [NBIT-1:0] regs [N_REG];

  logic            sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic            mosi_b;
  logic [7:0]      adr_byte;
  logic [6:0]      adr_off;
  logic [IW-1:0]   adr_idx;
  logic [IW-1:0]   nidx;
  logic            in_range;
  logic [NBIT-1:0] word;
  logic            unused;

  assign sclk_rise = (sclk_sr[3:1] == 3'b011);
  assign sclk_fall = (sclk_sr[3:1] == 3'b110);
  assign cs_fall   = (cs_sr[3:1] == 3'b110);
  assign cs_rise   = (cs_sr[3:1] == 3'b011);

  // mosi is delayed to the same depth as tap 2 of the sclk synchroniser
  assign mosi_b   = mosi_sr[2];
  assign adr_byte = {sh[6:0], mosi_b};
  assign adr_off  = adr_byte[6:0] - 7'(BASE_ADR);
  assign adr_idx  = adr_off[IW-1:0];
  assign in_range = ({1'b0, adr_byte[6:0]} >= 8'(BASE_ADR)) &&
                    ({1'b0, adr_byte[6:0]} <  8'(BASE_ADR + N_REG));
  assign word     = {sh[NBIT-2:0], mosi_b};
  assign nidx     = idx + IW'(1);
  assign unused   = ^{sclk_sr[4], cs_sr[4], adr_off[6:IW], sh[NBIT-1], rd_sr[NBIT-1], nidx};

  for (genvar k = 0; k < N_REG; k++) begin : g_out
    assign out[k*NBIT +: NBIT] = regs[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sclk_sr <= '0;
      cs_sr   <= '0;
      mosi_sr <= '0;
      cnt     <= '0;
      sh      <= '0;
      rd_sr   <= '0;
      idx     <= '0;
      hold    <= 1'b0;
      miso    <= 1'b1;
      busy    <= 1'b0;
      wr_stb  <= '0;
      for (int k = 0; k < N_REG; k++) regs[k] <= RST_VAL;
    end else begin
      sclk_sr <= {sclk_sr[3:0], sclk};
      cs_sr   <= {cs_sr[3:0], cs};
      mosi_sr <= {mosi_sr[1:0], mosi};
      wr_stb  <= '0;
      if (cs_rise) begin
        state <= IDLE;
        busy  <= 1'b0;
        miso  <= 1'b1;
        cnt   <= '0;
        hold  <= 1'b0;
      end else if (cs_fall) begin
        state <= ADDR;
        busy  <= 1'b1;
        miso  <= 1'b1;
        cnt   <= '0;
        hold  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (sclk_rise) begin
              sh  <= word;
              cnt <= cnt + 6'd1;
              if (cnt == 6'd7) begin
                cnt <= '0;
                if (!in_range) begin
                  state <= SKIP;
                end else begin
                  idx <= adr_idx;
                  if (adr_byte[7]) begin
                    state <= WR_DATA;
                  end else begin
                    // first data bit must be on miso before the next rise, so skip the coming fall
                    state <= RD_DATA;
                    rd_sr <= regs[adr_idx];
                    miso  <= regs[adr_idx][NBIT-1];
                    hold  <= 1'b1;
                  end
                end
              end
            end
          end
          WR_DATA: begin
            if (sclk_rise) begin
              sh  <= word;
              cnt <= cnt + 6'd1;
              if (cnt == 6'(NBIT-1)) begin
                cnt         <= '0;
                regs[idx]   <= word;
                wr_stb[idx] <= 1'b1;
`ifdef SPI_REG_BANK_AUTOINC_EN
                if (idx == IW'(N_REG-1)) state <= SKIP;
                else                     idx   <= nidx;
`else
                state <= SKIP;
`endif
              end
            end
          end
          RD_DATA: begin
            if (sclk_fall) begin
              if (hold) begin
                hold <= 1'b0;
              end else begin
                rd_sr <= {rd_sr[NBIT-2:0], 1'b0};
                miso  <= rd_sr[NBIT-2];
              end
            end
            if (sclk_rise) begin
              cnt <= cnt + 6'd1;
              if (cnt == 6'(NBIT-1)) begin
                cnt <= '0;
`ifdef SPI_REG_BANK_AUTOINC_EN
                if (idx == IW'(N_REG-1)) begin
                  state <= SKIP;
                  miso  <= 1'b1;
                end else begin
                  idx   <= nidx;
                  rd_sr <= regs[nidx];
                  miso  <= regs[nidx][NBIT-1];
                  hold  <= 1'b1;
                end
`else
                state <= SKIP;
                miso  <= 1'b1;
`endif
              end
            end
          end
          SKIP:    miso  <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: bit-banged SPI master, hand-computed expected values.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [63:0] out;
  logic [3:0]  wr_stb;
  logic        busy;

  spi_reg_bank #(.NBIT(16), .N_REG(4), .BASE_ADR(1), .RST_VAL(16'h0000)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .out(out), .wr_stb(wr_stb), .busy(busy)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          stb_cnt [4];
  int          stb_long = 0;
  logic [3:0]  stb_prev = 4'b0;
  logic [31:0] rx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (wr_stb[k] === 1'b1) stb_cnt[k]++;
    if ((wr_stb & stb_prev) != 4'b0) stb_long++;
    stb_prev = wr_stb;
  end

  function automatic logic [63:0] stb_pack();
    return {16'(stb_cnt[3]), 16'(stb_cnt[2]), 16'(stb_cnt[1]), 16'(stb_cnt[0])};
  endfunction

  task automatic clr_stb();
    for (int k = 0; k < 4; k++) stb_cnt[k] = 0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [31:0] d, input int n, output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      wait_clk(5);
      r[i] = miso;
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_hi();
    wait_clk(5);
    cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    logic [31:0] r;
    cs_lo();
    xfer({24'h0, a}, 8, r);
    xfer({16'h0, d}, 16, r);
    cs_hi();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) stb_cnt[k] = 0;

    wait_clk(3);
    check("rst_out", out, 64'h0);
    check("rst_stb", {60'h0, wr_stb}, 64'h0);
    check("rst_miso", {63'h0, miso}, 64'h1);
    check("rst_busy", {63'h0, busy}, 64'h0);
    rst = 1'b1;
    wait_clk(10);
    check("idle_miso", {63'h0, miso}, 64'h1);

    clr_stb();
    cs_lo();
    check("busy_sel", {63'h0, busy}, 64'h1);
    xfer(32'h82, 8, rx);
    xfer(32'hA5C3, 16, rx);
    cs_hi();
    check("busy_desel", {63'h0, busy}, 64'h0);
    check("wr_reg1", out, 64'h0000_0000_A5C3_0000);
    check("wr_reg1_stb", stb_pack(), 64'h0000_0000_0001_0000);

    wr(8'h83, 16'h1234);
    check("wr_reg2", out, 64'h0000_1234_A5C3_0000);

    cs_lo();
    xfer(32'h03, 8, rx);
    check("rd_addr_miso", {32'h0, rx}, 64'hFF);
    xfer(32'h0, 16, rx);
    check("rd_reg2", {32'h0, rx}, 64'h1234);
    cs_hi();
    check("rd_miso_idle", {63'h0, miso}, 64'h1);

    clr_stb();
    wr(8'h85, 16'hFFFF);
    check("oor_high", out, 64'h0000_1234_A5C3_0000);
    wr(8'h80, 16'hFFFF);
    check("oor_low", out, 64'h0000_1234_A5C3_0000);
    cs_lo();
    xfer(32'h81, 8, rx);
    xfer(32'hFF, 8, rx);
    cs_hi();
    check("abort_out", out, 64'h0000_1234_A5C3_0000);
    check("abort_stb", stb_pack(), 64'h0);

    clr_stb();
    wr(8'h84, 16'hBEEF);
    check("wr_reg3", out, 64'hBEEF_1234_A5C3_0000);
    check("wr_reg3_stb", stb_pack(), 64'h0001_0000_0000_0000);

    clr_stb();
    cs_lo();
    xfer(32'h81, 8, rx);
    for (int w = 1; w <= 5; w++) xfer(32'(w * 16'h1111), 16, rx);
    cs_hi();
`ifdef SPI_REG_BANK_AUTOINC_EN
    check("burst_out", out, 64'h4444_3333_2222_1111);
    check("burst_stb", stb_pack(), 64'h0001_0001_0001_0001);
`else
    check("burst_out", out, 64'hBEEF_1234_A5C3_1111);
    check("burst_stb", stb_pack(), 64'h0000_0000_0000_0001);
`endif

    cs_lo();
    xfer(32'h01, 8, rx);
    xfer(32'h0, 16, rx);
    check("rd_burst_w0", {32'h0, rx}, 64'h1111);
    xfer(32'h0, 16, rx);
`ifdef SPI_REG_BANK_AUTOINC_EN
    check("rd_burst_w1", {32'h0, rx}, 64'h2222);
`else
    check("rd_burst_w1", {32'h0, rx}, 64'hFFFF);
`endif
    cs_hi();
    check("stb_width", 64'(stb_long), 64'h0);

    clr_stb();
    cs_lo();
    xfer(32'h82, 8, rx);
    xfer(32'h1FF, 9, rx);
    rst = 1'b0;
    #1;
    check("arst_out", out, 64'h0);
    check("arst_busy", {63'h0, busy}, 64'h0);
    check("arst_miso", {63'h0, miso}, 64'h1);
    cs = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(10);
    wr(8'h81, 16'h00C3);
    check("post_rst_wr", out, 64'h0000_0000_0000_00C3);
    check("post_rst_stb", stb_pack(), 64'h0000_0000_0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
